ysyx_22050710_csr_unit: RTL and testbench

Parametrised machine-mode CSR file plus trap sequencer for the NPC core, sitting beside the register file at the execute/commit point. It holds nine M-mode CSRs and performs CSR read-modify-write (RW/RS/RC). It sequences ecall, mret and the machine timer interrupt, including mstatus MIE/MPIE stacking and vectored mtvec. It also runs free-running cycle and instret counters.

---
 rtl/ysyx_22050710_csr_unit_if.sv | 31 +++
 rtl/ysyx_22050710_csr_unit.sv | 241 ++++++++++++++++++++++++
 tb/tb_ysyx_22050710_csr_unit.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_22050710_csr_unit_if.sv
// Commit-side bus of the machine-mode CSR unit: the committing instruction's
// CSR access, trap requests and the timer line in; read data and redirect out.
interface ysyx_22050710_csr_unit_if #(
  parameter int XLEN = 64
);
  logic            i_valid;
  logic [XLEN-1:0] i_pc;
  logic [11:0]     i_csr_addr;
  logic [1:0]      i_csr_op;
  logic [XLEN-1:0] i_csr_wdata;
  logic            i_ecall;
  logic            i_mret;
  logic            i_irq_timer;
  logic [XLEN-1:0] o_csr_rdata;
  logic            o_illegal;
  logic            o_trap;
  logic            o_squash;
  logic [XLEN-1:0] o_nextpc;

  modport master (
    output i_valid, i_pc, i_csr_addr, i_csr_op, i_csr_wdata,
           i_ecall, i_mret, i_irq_timer,
    input  o_csr_rdata, o_illegal, o_trap, o_squash, o_nextpc
  );

  modport slave (
    input  i_valid, i_pc, i_csr_addr, i_csr_op, i_csr_wdata,
           i_ecall, i_mret, i_irq_timer,
    output o_csr_rdata, o_illegal, o_trap, o_squash, o_nextpc
  );
endinterface

// File: rtl/ysyx_22050710_csr_unit.sv
// Machine-mode CSR file and trap sequencer for the NPC core.
// Holds mstatus/mie/mtvec/mscratch/mepc/mcause/mip and, when the macro
// YSYX_CSR_COUNTERS_EN is defined, the mcycle/minstret counters. Without the
// macro the counter addresses decode as unknown and raise o_illegal.
// Trap priority on a committing instruction: timer interrupt > ecall > mret
// > CSR op. All redirect decisions are combinational; state lands at the
// next clock edge.
module ysyx_22050710_csr_unit #(
  parameter int              XLEN          = 64,
  parameter logic [63:0]     MSTATUS_RESET = 64'ha00001800,
  parameter logic [XLEN-1:0] MTVEC_RESET   = '0
) (
  input logic i_clk,
  input logic i_rst,
  ysyx_22050710_csr_unit_if.slave bus
);

  localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
  localparam logic [11:0] ADDR_MIE      = 12'h304;
  localparam logic [11:0] ADDR_MTVEC    = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
  localparam logic [11:0] ADDR_MEPC     = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
  localparam logic [11:0] ADDR_MIP      = 12'h344;
`ifdef YSYX_CSR_COUNTERS_EN
  localparam logic [11:0] ADDR_MCYCLE   = 12'hb00;
  localparam logic [11:0] ADDR_MINSTRET = 12'hb02;
`endif

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_RW   = 2'b01;
  localparam logic [1:0] OP_RS   = 2'b10;
  localparam logic [1:0] OP_RC   = 2'b11;

  // mstatus bits other than MIE/MPIE are read-only constants taken from the
  // reset value, with MPP pinned to machine mode.
  localparam logic [XLEN-1:0] MSTATUS_RST   = MSTATUS_RESET[XLEN-1:0];
  localparam logic [XLEN-1:0] MSTATUS_WMASK = {{(XLEN-8){1'b0}}, 8'h88};
  localparam logic [XLEN-1:0] MSTATUS_MPP   = {{(XLEN-13){1'b0}}, 2'b11, 11'b0};
  localparam logic [XLEN-1:0] MSTATUS_FIXED =
    (MSTATUS_RST & ~MSTATUS_WMASK) | MSTATUS_MPP;

  localparam logic [XLEN-1:0] CAUSE_TIMER = {1'b1, {(XLEN-4){1'b0}}, 3'd7};
  localparam logic [XLEN-1:0] CAUSE_ECALL = {{(XLEN-4){1'b0}}, 4'd11};
  localparam logic [XLEN-1:0] TIMER_VEC_OFS = {{(XLEN-5){1'b0}}, 5'd28};
  localparam logic [XLEN-1:0] ONE = {{(XLEN-1){1'b0}}, 1'b1};

  // architectural state
  logic            mstatus_mie;
  logic            mstatus_mpie;
  logic            mie_mtie;
  logic            mtip_q;
  logic [XLEN-1:0] mtvec;
  logic [XLEN-1:0] mscratch;
  logic [XLEN-1:0] mepc;
  logic [XLEN-1:0] mcause;
`ifdef YSYX_CSR_COUNTERS_EN
  logic [XLEN-1:0] mcycle;
  logic [XLEN-1:0] minstret;
`endif

  // read views and decode
  logic [XLEN-1:0] mstatus_val;
  logic [XLEN-1:0] mie_val;
  logic [XLEN-1:0] mip_val;
  logic [XLEN-1:0] csr_old;
  logic [XLEN-1:0] csr_new;
  logic            addr_known;

  // trap control
  logic            irq_pend;
  logic            take_irq;
  logic            take_ecall;
  logic            take_mret;
  logic            trap_any;
  logic            op_active;
  logic            csr_wen;
  logic [XLEN-1:0] trap_base;
  logic [XLEN-1:0] nextpc;

  // pc[1:0] never reaches mepc, which is always word aligned
  logic unused_pc_lsb;
  assign unused_pc_lsb = ^bus.i_pc[1:0];

  // Assemble the architectural images of the partially implemented CSRs.
  always_comb begin
    mstatus_val    = MSTATUS_FIXED;
    mstatus_val[3] = mstatus_mie;
    mstatus_val[7] = mstatus_mpie;
    mie_val        = '0;
    mie_val[7]     = mie_mtie;
    mip_val        = '0;
    mip_val[7]     = mtip_q;
  end

  // Address decode: return the pre-write value and flag unknown addresses.
  always_comb begin
    csr_old    = '0;
    addr_known = 1'b1;
    case (bus.i_csr_addr)
      ADDR_MSTATUS:  csr_old = mstatus_val;
      ADDR_MIE:      csr_old = mie_val;
      ADDR_MTVEC:    csr_old = mtvec;
      ADDR_MSCRATCH: csr_old = mscratch;
      ADDR_MEPC:     csr_old = mepc;
      ADDR_MCAUSE:   csr_old = mcause;
      ADDR_MIP:      csr_old = mip_val;
`ifdef YSYX_CSR_COUNTERS_EN
      ADDR_MCYCLE:   csr_old = mcycle;
      ADDR_MINSTRET: csr_old = minstret;
`endif
      default:       addr_known = 1'b0;
    endcase
  end

  // Read-modify-write result for the addressed CSR.
  always_comb begin
    case (bus.i_csr_op)
      OP_RW:   csr_new = bus.i_csr_wdata;
      OP_RS:   csr_new = csr_old | bus.i_csr_wdata;
      OP_RC:   csr_new = csr_old & ~bus.i_csr_wdata;
      default: csr_new = csr_old;
    endcase
  end

  assign irq_pend   = mstatus_mie & mie_mtie & mtip_q;
  assign take_irq   = bus.i_valid & irq_pend;
  assign take_ecall = bus.i_valid & ~irq_pend & bus.i_ecall;
  assign take_mret  = bus.i_valid & ~irq_pend & ~bus.i_ecall & bus.i_mret;
  assign trap_any   = take_irq | take_ecall | take_mret;
  assign op_active  = bus.i_valid & (bus.i_csr_op != OP_NONE);
  // a trap cancels the CSR op; unknown addresses never write
  assign csr_wen    = op_active & addr_known & ~trap_any;
  assign trap_base  = {mtvec[XLEN-1:2], 2'b00};

  // Redirect target: mret returns to mepc; vectored mode only offsets
  // interrupts, exceptions always enter at the base.
  always_comb begin
    if (take_mret) begin
      nextpc = mepc;
    end else if (take_irq && (mtvec[1:0] == 2'b01)) begin
      nextpc = trap_base + TIMER_VEC_OFS;
    end else begin
      nextpc = trap_base;
    end
  end

  assign bus.o_csr_rdata = i_rst ? '0 : csr_old;
  assign bus.o_illegal   = ~i_rst & op_active & ~addr_known;
  assign bus.o_trap      = ~i_rst & trap_any;
  assign bus.o_squash    = ~i_rst & take_irq;
  assign bus.o_nextpc    = i_rst ? '0 : nextpc;

  // mstatus MIE/MPIE stacking; trap entry and mret take precedence over writes.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mstatus_mie  <= MSTATUS_RST[3];
      mstatus_mpie <= MSTATUS_RST[7];
    end else if (take_irq || take_ecall) begin
      mstatus_mpie <= mstatus_mie;
      mstatus_mie  <= 1'b0;
    end else if (take_mret) begin
      mstatus_mie  <= mstatus_mpie;
      mstatus_mpie <= 1'b1;
    end else if (csr_wen && (bus.i_csr_addr == ADDR_MSTATUS)) begin
      mstatus_mie  <= csr_new[3];
      mstatus_mpie <= csr_new[7];
    end
  end

  // Trap entry records the faulting pc and cause over any same-cycle write.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mepc   <= '0;
      mcause <= '0;
    end else if (take_irq || take_ecall) begin
      mepc   <= {bus.i_pc[XLEN-1:2], 2'b00};
      mcause <= take_irq ? CAUSE_TIMER : CAUSE_ECALL;
    end else if (csr_wen) begin
      if (bus.i_csr_addr == ADDR_MEPC) begin
        mepc <= {csr_new[XLEN-1:2], 2'b00};
      end
      if (bus.i_csr_addr == ADDR_MCAUSE) begin
        mcause <= csr_new;
      end
    end
  end

  // Plain software-written CSRs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mie_mtie <= 1'b0;
      mtvec    <= MTVEC_RESET;
      mscratch <= '0;
    end else if (csr_wen) begin
      if (bus.i_csr_addr == ADDR_MIE) begin
        mie_mtie <= csr_new[7];
      end
      if (bus.i_csr_addr == ADDR_MTVEC) begin
        mtvec <= csr_new;
      end
      if (bus.i_csr_addr == ADDR_MSCRATCH) begin
        mscratch <= csr_new;
      end
    end
  end

  // Register the timer level; it feeds both mip.MTIP and the pending check.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mtip_q <= 1'b0;
    end else begin
      mtip_q <= bus.i_irq_timer;
    end
  end

`ifdef YSYX_CSR_COUNTERS_EN
  // Free-running counters; a software write in the same cycle wins.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mcycle   <= '0;
      minstret <= '0;
    end else begin
      if (csr_wen && (bus.i_csr_addr == ADDR_MCYCLE)) begin
        mcycle <= csr_new;
      end else begin
        mcycle <= mcycle + ONE;
      end
      if (csr_wen && (bus.i_csr_addr == ADDR_MINSTRET)) begin
        minstret <= csr_new;
      end else if (bus.i_valid && !take_irq) begin
        minstret <= minstret + ONE;
      end
    end
  end
`else
  logic unused_one;
  assign unused_one = ^ONE;
`endif

endmodule

// File: tb/tb_ysyx_22050710_csr_unit.sv
// Scoreboard bench for ysyx_22050710_csr_unit. A stimulus process drives one
// commit per cycle, evaluates a CSR-array reference model and queues the
// expected outputs; a monitor compares them on the falling edge.
module tb_ysyx_22050710_csr_unit;
  logic clk;
  logic rst;

  ysyx_22050710_csr_unit_if #(.XLEN(64)) bus ();

  ysyx_22050710_csr_unit #(.XLEN(64)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] rdata;
    logic        illegal;
    logic        trap;
    logic        squash;
    logic [63:0] nextpc;
  } exp_t;

  exp_t sbq[$];
  int   checks   = 0;
  int   failures = 0;
  bit   counters_on;

  // reference model: one variable per architectural CSR image
  logic [63:0] m_mstatus, m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause;
  logic [63:0] m_mip, m_cycle, m_instret;

  function automatic bit m_known(input logic [11:0] a);
    case (a)
      12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h344: return 1'b1;
      12'hb00, 12'hb02: return counters_on;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [63:0] m_rd(input logic [11:0] a);
    case (a)
      12'h300: return m_mstatus;
      12'h304: return m_mie;
      12'h305: return m_mtvec;
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h344: return m_mip;
      12'hb00: return counters_on ? m_cycle : 64'h0;
      12'hb02: return counters_on ? m_instret : 64'h0;
      default: return 64'h0;
    endcase
  endfunction

  task automatic m_reset();
    m_mstatus = 64'ha00001800; m_mie = 0; m_mtvec = 0; m_mscratch = 0;
    m_mepc = 0; m_mcause = 0; m_mip = 0; m_cycle = 0; m_instret = 0;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus: drive, predict, queue, then advance past the edge.
  task automatic step(input bit r, input bit valid, input logic [63:0] pc,
                      input logic [11:0] a, input logic [1:0] op,
                      input logic [63:0] wd, input bit ec, input bit mr,
                      input bit irq);
    exp_t e;
    logic [63:0] old, nv, base, cyc_n, ins_n;
    bit irqp;
    rst = r;
    bus.i_valid = valid; bus.i_pc = pc; bus.i_csr_addr = a; bus.i_csr_op = op;
    bus.i_csr_wdata = wd; bus.i_ecall = ec; bus.i_mret = mr; bus.i_irq_timer = irq;
    e = '{64'h0, 1'b0, 1'b0, 1'b0, 64'h0};
    if (r) begin
      m_reset();
    end else begin
      old = m_rd(a);
      e.rdata = old;
      e.illegal = valid && op != 2'b00 && !m_known(a);
      irqp = m_mstatus[3] && m_mie[7] && m_mip[7];
      base = m_mtvec & ~64'h3;
      cyc_n = m_cycle + 1;
      ins_n = m_instret + ((valid && !irqp) ? 64'd1 : 64'd0);
      if (valid && irqp) begin
        e.trap = 1; e.squash = 1;
        e.nextpc = (m_mtvec[1:0] == 2'b01) ? base + 64'd28 : base;
        m_mepc = pc & ~64'h3;
        m_mcause = 64'h8000000000000007;
        m_mstatus[7] = m_mstatus[3]; m_mstatus[3] = 1'b0;
      end else if (valid && ec) begin
        e.trap = 1; e.nextpc = base;
        m_mepc = pc & ~64'h3;
        m_mcause = 64'd11;
        m_mstatus[7] = m_mstatus[3]; m_mstatus[3] = 1'b0;
      end else if (valid && mr) begin
        e.trap = 1; e.nextpc = m_mepc;
        m_mstatus[3] = m_mstatus[7]; m_mstatus[7] = 1'b1;
      end else if (valid && op != 2'b00 && m_known(a)) begin
        nv = (op == 2'b01) ? wd : (op == 2'b10) ? (old | wd) : (old & ~wd);
        case (a)
          12'h300: m_mstatus = (m_mstatus & ~64'h88) | (nv & 64'h88);
          12'h304: m_mie = nv & 64'h80;
          12'h305: m_mtvec = nv;
          12'h340: m_mscratch = nv;
          12'h341: m_mepc = nv & ~64'h3;
          12'h342: m_mcause = nv;
          12'hb00: cyc_n = nv;
          12'hb02: ins_n = nv;
          default: ;
        endcase
      end
      m_cycle = cyc_n;
      m_instret = ins_n;
      m_mip = irq ? 64'h80 : 64'h0;
    end
    sbq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [11:0] a);
    step(0, 0, 64'h0, a, 2'b00, 64'h0, 0, 0, 0);
  endtask

  task automatic csr(input logic [11:0] a, input logic [1:0] op, input logic [63:0] wd);
    step(0, 1, 64'h80000000, a, op, wd, 0, 0, 0);
  endtask

  // monitor: compare whatever the DUT presents against the oldest prediction
  always @(negedge clk) begin
    exp_t e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      check("rdata", bus.o_csr_rdata, e.rdata);
      check("illegal", {63'h0, bus.o_illegal}, {63'h0, e.illegal});
      check("trap", {63'h0, bus.o_trap}, {63'h0, e.trap});
      check("squash", {63'h0, bus.o_squash}, {63'h0, e.squash});
      if (e.trap) check("nextpc", bus.o_nextpc, e.nextpc);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [11:0] al [11];
    logic [63:0] wsel [6];
    logic [63:0] wd;
`ifdef YSYX_CSR_COUNTERS_EN
    counters_on = 1'b1;
`else
    counters_on = 1'b0;
`endif
    al = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
           12'h344, 12'hb00, 12'hb02, 12'h7c0, 12'h301};
    wsel = '{64'h8, 64'h80, 64'h88, 64'h80000101, 64'h80000100, 64'h3};
    rst = 1'b1;
    bus.i_valid = 0; bus.i_pc = 0; bus.i_csr_addr = 0; bus.i_csr_op = 0;
    bus.i_csr_wdata = 0; bus.i_ecall = 0; bus.i_mret = 0; bus.i_irq_timer = 0;
    m_reset();
    @(posedge clk);
    #1;

    // reset values
    step(1, 1, 64'h80000000, 12'h300, 2'b01, 64'hff, 1, 0, 1);
    step(1, 0, 64'h0, 12'h300, 2'b00, 64'h0, 0, 0, 0);
    rd(12'h300); rd(12'h305); rd(12'h341); rd(12'h344);

    // read-modify-write ops
    csr(12'h305, 2'b01, 64'h80000101);
    csr(12'h300, 2'b10, 64'h8);
    rd(12'h300);
    csr(12'h300, 2'b11, 64'h8);
    rd(12'h300); rd(12'h305);

    // ecall then mret
    csr(12'h305, 2'b01, 64'h80000100);
    csr(12'h300, 2'b10, 64'h8);
    step(0, 1, 64'h80000040, 12'h000, 2'b00, 64'h0, 1, 0, 0);
    rd(12'h341); rd(12'h342); rd(12'h300);
    step(0, 1, 64'h80000100, 12'h000, 2'b00, 64'h0, 0, 1, 0);
    rd(12'h300);

    // vectored timer interrupt squashing a CSR write
    csr(12'h305, 2'b01, 64'h80000101);
    csr(12'h304, 2'b10, 64'h80);
    csr(12'h300, 2'b10, 64'h8);
    step(0, 0, 64'h0, 12'h344, 2'b00, 64'h0, 0, 0, 1);
    step(0, 1, 64'h80000200, 12'h340, 2'b01, 64'h5, 0, 0, 1);
    rd(12'h340); rd(12'h342); rd(12'h341); rd(12'hb02); rd(12'h300);

    // unknown address
    csr(12'h7c0, 2'b01, 64'hffff);
    rd(12'h300); rd(12'h305);
    csr(12'hb00, 2'b10, 64'h0);

    // counter wrap
    csr(12'hb00, 2'b01, 64'hffffffffffffffff);
    rd(12'hb00); rd(12'hb00);

    // randomized traffic, including occasional mid-stream resets
    for (int n = 0; n < 800; n++) begin
      wd = ($urandom_range(0, 1) != 0) ? {$urandom, $urandom} : wsel[$urandom_range(0, 5)];
      step(($urandom_range(0, 79) == 0), ($urandom_range(0, 3) != 0),
           {$urandom, $urandom}, al[$urandom_range(0, 10)],
           2'($urandom_range(0, 3)), wd,
           ($urandom_range(0, 11) == 0), ($urandom_range(0, 11) == 0),
           ($urandom_range(0, 2) != 0));
    end
    rd(12'h300);

    for (int k = 0; k < 10 && sbq.size() > 0; k++) @(posedge clk);
    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d expected=0", sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
